// File: rtl/mips_hazard_pkg.sv
// ============================================================================
// mips_hazard_pkg : shared encodings and shadow-stage types for hazard_ctrl
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] FWD_NONE  = 3'd0;
  localparam logic [2:0] FWD_E_PC8 = 3'd1;
  localparam logic [2:0] FWD_M_AO  = 3'd2;
  localparam logic [2:0] FWD_M_PC8 = 3'd3;
  localparam logic [2:0] FWD_W     = 3'd4;

  // A Tuse of 3 can never be exceeded by any Tnew (max 2), so it means "unused".
  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [4:0] REG_RA    = 5'd31;

  typedef enum logic [1:0] {
    WSRC_ALU = 2'd0,
    WSRC_MEM = 2'd1,
    WSRC_PC8 = 2'd2
  } wsrc_e;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] dest;
    logic [1:0] tnew;
    wsrc_e      wsrc;
  } shadow_t;

  localparam shadow_t SHADOW_EMPTY = '{rt: 5'd0, dest: 5'd0, tnew: 2'd0, wsrc: WSRC_ALU};

  function automatic logic [1:0] tnew_step(input logic [1:0] tnew);
    return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
  endfunction

  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input shadow_t e, input shadow_t m);
    logic w_hit;
    w_hit = 1'b0;
    if (src != 5'd0) begin
      if ((e.dest == src) && (e.tnew > tuse)) w_hit = 1'b1;
      if ((m.dest == src) && (m.tnew > tuse)) w_hit = 1'b1;
    end
    return w_hit;
  endfunction

  // Youngest matching producer decides; an older match behind it is never used.
  function automatic logic [2:0] fwd_select(input logic [4:0] r,
                                            input logic use_e, input shadow_t e,
                                            input logic use_m, input shadow_t m,
                                            input logic [4:0] w_dest);
    logic [2:0] w_sel;
    w_sel = FWD_NONE;
    if (r == 5'd0) begin
      w_sel = FWD_NONE;
    end else if (use_e && (e.dest == r)) begin
      if ((e.tnew == 2'd0) && (e.wsrc == WSRC_PC8)) w_sel = FWD_E_PC8;
    end else if (use_m && (m.dest == r)) begin
      if (m.tnew == 2'd0) begin
        if (m.wsrc == WSRC_ALU)      w_sel = FWD_M_AO;
        else if (m.wsrc == WSRC_PC8) w_sel = FWD_M_PC8;
      end
    end else if (w_dest == r) begin
      w_sel = FWD_W;
    end
    return w_sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_decode.sv
// ============================================================================
// hazard_decode : IR -> register operands, use/produce timing, write source
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_decode
  import mips_hazard_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [1:0]  o_tuse_rs,
  output logic [1:0]  o_tuse_rt,
  output logic [4:0]  o_dest,
  output logic [1:0]  o_tnew,
  output wsrc_e       o_wsrc
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rd;
  logic       w_unused_shamt;

  assign w_op           = i_ir[31:26];
  assign w_funct        = i_ir[5:0];
  assign w_rd           = i_ir[15:11];
  assign o_rs           = i_ir[25:21];
  assign o_rt           = i_ir[20:16];
  assign w_unused_shamt = ^i_ir[10:6];

  always_comb begin
    o_tuse_rs = TUSE_NONE;
    o_tuse_rt = TUSE_NONE;
    o_dest    = 5'd0;
    o_tnew    = 2'd0;
    o_wsrc    = WSRC_ALU;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADDU, FN_SUBU: begin
            o_tuse_rs = 2'd1;
            o_tuse_rt = 2'd1;
            o_dest    = w_rd;
            o_tnew    = 2'd1;
          end
          FN_JR: o_tuse_rs = 2'd0;
          default: ;
        endcase
      end
      OP_ORI: begin
        o_tuse_rs = 2'd1;
        o_dest    = o_rt;
        o_tnew    = 2'd1;
      end
      OP_LUI: begin
        o_dest = o_rt;
        o_tnew = 2'd1;
      end
      OP_LW: begin
        o_tuse_rs = 2'd1;
        o_dest    = o_rt;
        o_tnew    = 2'd2;
        o_wsrc    = WSRC_MEM;
      end
      OP_SW: begin
        o_tuse_rs = 2'd1;
        o_tuse_rt = 2'd2;
      end
      OP_BEQ: begin
        o_tuse_rs = 2'd0;
        o_tuse_rt = 2'd0;
      end
      OP_JAL: begin
        o_dest = REG_RA;
        o_tnew = 2'd0;
        o_wsrc = WSRC_PC8;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : stall/flush/forward control from IRD and an E/M/W shadow pipe
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import mips_hazard_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IRD,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic [2:0]  Forward_RS_D_Sel,
  output logic [2:0]  Forward_RT_D_Sel,
  output logic [2:0]  Forward_RS_E_Sel,
  output logic [2:0]  Forward_RT_E_Sel,
  output logic [2:0]  Forward_RT_M_Sel
);

  logic [4:0] w_d_rs;
  logic [4:0] w_d_rt;
  logic [1:0] w_d_tuse_rs;
  logic [1:0] w_d_tuse_rt;
  logic [4:0] w_d_dest;
  logic [1:0] w_d_tnew;
  wsrc_e      w_d_wsrc;

  shadow_t    r_e;
  logic [4:0] r_e_rs;
  shadow_t    r_m;
  logic [4:0] r_w_dest;

  logic       w_stall;
  logic [2:0] w_fwd_rs_d;
  logic [2:0] w_fwd_rt_d;
  logic [2:0] w_fwd_rs_e;
  logic [2:0] w_fwd_rt_e;
  logic [2:0] w_fwd_rt_m;
  shadow_t    w_e_next;
  shadow_t    w_m_next;

  hazard_decode u_decode (
    .i_ir      (IRD),
    .o_rs      (w_d_rs),
    .o_rt      (w_d_rt),
    .o_tuse_rs (w_d_tuse_rs),
    .o_tuse_rt (w_d_tuse_rt),
    .o_dest    (w_d_dest),
    .o_tnew    (w_d_tnew),
    .o_wsrc    (w_d_wsrc)
  );

  always_comb begin
    w_stall = src_hazard(w_d_rs, w_d_tuse_rs, r_e, r_m) |
              src_hazard(w_d_rt, w_d_tuse_rt, r_e, r_m);

    w_fwd_rs_d = fwd_select(w_d_rs, 1'b1, r_e, 1'b1, r_m, r_w_dest);
    w_fwd_rt_d = fwd_select(w_d_rt, 1'b1, r_e, 1'b1, r_m, r_w_dest);
    w_fwd_rs_e = fwd_select(r_e_rs, 1'b0, r_e, 1'b1, r_m, r_w_dest);
    w_fwd_rt_e = fwd_select(r_e.rt, 1'b0, r_e, 1'b1, r_m, r_w_dest);
    w_fwd_rt_m = fwd_select(r_m.rt, 1'b0, r_e, 1'b0, r_m, r_w_dest);

    w_e_next      = SHADOW_EMPTY;
    w_e_next.rt   = w_d_rt;
    w_e_next.dest = w_d_dest;
    w_e_next.tnew = w_d_tnew;
    w_e_next.wsrc = w_d_wsrc;

    w_m_next      = r_e;
    w_m_next.tnew = tnew_step(r_e.tnew);
  end

  // Outputs are gated so nothing escapes while the core is held in reset.
  assign StallF           = Reset & w_stall;
  assign StallD           = Reset & w_stall;
  assign FlushE           = Reset & w_stall;
  assign Forward_RS_D_Sel = Reset ? w_fwd_rs_d : FWD_NONE;
  assign Forward_RT_D_Sel = Reset ? w_fwd_rt_d : FWD_NONE;
  assign Forward_RS_E_Sel = Reset ? w_fwd_rs_e : FWD_NONE;
  assign Forward_RT_E_Sel = Reset ? w_fwd_rt_e : FWD_NONE;
  assign Forward_RT_M_Sel = Reset ? w_fwd_rt_m : FWD_NONE;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_e      <= SHADOW_EMPTY;
      r_e_rs   <= 5'd0;
      r_m      <= SHADOW_EMPTY;
      r_w_dest <= 5'd0;
    end else begin
      if (w_stall) begin
        r_e    <= SHADOW_EMPTY;
        r_e_rs <= 5'd0;
      end else begin
        r_e    <= w_e_next;
        r_e_rs <= w_d_rs;
      end
      r_m      <= w_m_next;
      r_w_dest <= r_m.dest;
    end
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It watches the instruction word leaving F (IRD) and keeps a shadow pipeline of the E/M/W destination and result-timing state. Each cycle it drives the stall, flush and forwarding-select inputs of the datapath. It is the control-side counterpart of the datapath: it consumes IRD and produces StallF, StallD, FlushE and Forward_*_Sel.

## Interface
- No parameters. The instruction set is fixed: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, nop.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low; clears all shadow state.
- IRD  in  32  instruction currently in D.
- StallF  out  1  hold PC.
- StallD  out  1  hold the D pipeline register.
- FlushE  out  1  load a bubble into E.
- Forward_RS_D_Sel, Forward_RT_D_Sel  out  3  D-stage comparator/NPC operand source.
- Forward_RS_E_Sel, Forward_RT_E_Sel  out  3  ALU operand source.
- Forward_RT_M_Sel  out  3  store-data source.

## Operation
- Forward codes, shared by all selects:
  - 0: register or pipeline value (no forward)
  - 1: PC4E+4 (PC8 of the instruction in E)
  - 2: AOM
  - 3: PC4M+4
  - 4: MUX_RF_WD_OUT from W
- Decode of IRD yields rs, rt, Tuse_rs, Tuse_rt, dest, Tnew, wsrc ∈ {ALU, MEM, PC8}.
- Tuse values (3 = unused):
  - beq: rs 0, rt 0
  - jr: rs 0
  - addu/subu: rs 1, rt 1
  - ori/lw: rs 1
  - sw: rs 1, rt 2
  - all other register operands: 3
- Tnew in E and dest:
  - addu/subu: Tnew 1, dest rd
  - ori/lui: Tnew 1, dest rt
  - lw: Tnew 2, dest rt
  - jal: Tnew 0, dest 31
  - all others: dest 0 (no write)
- Shadow E register {rs, rt, dest, tnew, wsrc}: loaded from the decode of IRD, or all-zero when FlushE.
- Shadow M register {rt, dest, tnew, wsrc}: loaded from E, with tnew = max(tnewE−1, 0).
- Shadow W register {dest}: loaded from M; W tnew is always 0.
- Stall: for src ∈ {rs, rt} with src ≠ 0, stall when stage X ∈ {E, M} has destX == src and tnewX > Tuse_src.
  - Any stall asserts StallF = StallD = FlushE = 1 in the same cycle.
- Forwarding for a consumer at stage S (D, E or M) reading register r ≠ 0:
  - Only the youngest stage strictly after S with dest == r is considered.
  - If that stage's tnew == 0, select by stage and wsrc:
    - E, PC8 → 1
    - M, ALU → 2
    - M, PC8 → 3
    - W → 4
  - Otherwise select 0.
  - No match also selects 0.
  - The register file is not write-through, so code 4 is required for D.
- The E-stage selects use shadow E rs/rt. Forward_RT_M_Sel uses shadow M rt and only the W stage.

## Timing
- Outputs are combinational from IRD and shadow state, valid within the same cycle. There is no added latency.
- Shadow registers advance on every Clk rising edge. D is never frozen internally; IRD is held by the datapath under StallD.
- Reset low: all shadow registers are 0 immediately and all outputs are forced to 0 regardless of IRD.
- Reset release mid-program: operation starts clean on the first edge, with no spurious stall.
- Simultaneous E and M matches: E wins. Matches against $0 are ignored.
- A stall lasts exactly until the producer's tnew ≤ Tuse. Examples:
  - lw→beq: 2 cycles.
  - lw→addu: 1 cycle.
  - addu→beq: 1 cycle.
  - lw→sw rt: 0 cycles (forwarded M←W).

## Structure
- Package mips_hazard_pkg holds:
  - opcode/funct constants
  - FWD_NONE/FWD_E_PC8/FWD_M_AO/FWD_M_PC8/FWD_W codes
  - WSRC enum
  - a shadow-stage struct typedef
- One combinational sub-module, hazard_decode: IR → {rs, rt, tuse_rs, tuse_rt, dest, tnew, wsrc}, instantiated once on IRD.
- Shadow registers, stall and forward logic live in hazard_ctrl.

## Test plan
- Reset held low with IRD=lw $1,0($0) (0x8C010000) → all outputs 0. Release → one edge later the shadow E dest is 1.
- lw $1,0($0) then beq $1,$2 → stalls for 2 cycles, FlushE on both. Third cycle: Forward_RS_D_Sel=4, no stall.
- addu $3,$1,$2 then subu $4,$3,$3 → no stall, Forward_RS_E_Sel=Forward_RT_E_Sel=2 in the consumer's E cycle.
- jal then jr $31 → no stall, Forward_RS_D_Sel=1.
- lw $5,0($0); sw $5,4($0) → no stall, Forward_RT_M_Sel=4 when sw is in M.
- addu $0,$1,$2 then beq $0,$0 → no stall, all selects 0.
